pa_tile_seq: RTL and testbench

//  Parametrised tile sequencer for the processing array (PA); successor to the fixed 16-row sequencer.

---
 rtl/pa_pkg.sv | 17 +
 rtl/pa_beat_cnt.sv | 26 ++
 rtl/pa_tile_seq.sv | 182 ++++++++++++++++++
 tb/tb_pa_tile_seq.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_pkg.sv
// Shared types and constants for the processing-array tile sequencer.
package pa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOADW = 2'd1,
    ST_COMP  = 2'd2,
    ST_WB    = 2'd3
  } pa_state_e;

  localparam logic [1:0] SEL_BIAS  = 2'd0;
  localparam logic [1:0] SEL_MULT  = 2'd1;
  localparam logic [1:0] SEL_SHIFT = 2'd2;

  localparam int TRAILER_BEATS = 3;

endpackage

// File: rtl/pa_beat_cnt.sv
// Wrapping beat counter: counts 0..last on enable, sync clear, terminal-count flag.
module pa_beat_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         counter_rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == last);

  always_ff @(posedge clk or negedge counter_rst_n) begin
    if (!counter_rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pa_tile_seq.sv
// Tile sequencer for the PA: weight load, compute passes and result drain per tile.
// Optional quantisation trailer beats per weight row: define PA_TILE_SEQ_QUANT_PARAM_EN.
module pa_tile_seq
  import pa_pkg::*;
#(
  parameter int PA_ROWS  = 16,
  parameter int LHS_STEP = 4,
  parameter int COL_AW   = 9,
  parameter int CFG_W    = 32
) (
  input  logic                               clk,
  input  logic                               counter_rst_n,
  input  logic                               start,
  input  logic [CFG_W-1:0]                   rhs_rows,
  input  logic [CFG_W-1:0]                   rhs_cols,
  input  logic [CFG_W-1:0]                   lhs_rows,
  input  logic                               data_rd_rdy,
  output logic                               data_rd_acq,
  input  logic                               weight_rd_rdy,
  output logic                               weight_rd_acq,
  output logic                               dst_wr_rdy,
  input  logic                               dst_wr_acq,
  output logic [$clog2(PA_ROWS)+COL_AW-1:0]  wr_ram_addr,
  output logic [COL_AW-1:0]                  rd_ram_addr,
  output logic                               ram_wr,
  output logic                               buf_wr,
  output logic [1:0]                         buf_wr_sel,
  output logic                               pa_en,
  output logic                               row_sum_clr,
  output logic [$clog2(PA_ROWS)-1:0]         result_addr,
  output logic [1:0]                         state,
  output logic                               done
);

  localparam int RW = $clog2(PA_ROWS);

  pa_state_e        st, st_nxt;
  logic [CFG_W-1:0] rhs_rows_q, rhs_cols_q, lhs_rows_q;
  logic [CFG_W-1:0] tile_base, lhs_base, tile_rem, tile_rows;
  logic [CFG_W:0]   lhs_nxt, tile_nxt;
  logic [RW-1:0]    row_last, row_cnt, lane_cnt;
  logic [COL_AW-1:0] col_last, col_cnt;
  logic ld_beat, comp_beat, wb_beat, in_trl, row_end;
  logic col_tc, row_tc, lane_tc, st_chg;
  logic latch, done_set, pass_adv, tile_adv, comp_entry, done_q;

  assign weight_rd_acq = (st == ST_LOADW);
  assign data_rd_acq   = (st == ST_COMP);
  assign dst_wr_rdy    = (st == ST_WB);

  assign ld_beat   = weight_rd_rdy & weight_rd_acq;
  assign comp_beat = data_rd_rdy & data_rd_acq;
  assign wb_beat   = dst_wr_rdy & dst_wr_acq;

  // Partial last tile: only the remaining rhs rows are loaded and drained.
  assign tile_rem  = rhs_rows_q - tile_base;
  assign tile_rows = (tile_rem > CFG_W'(PA_ROWS)) ? CFG_W'(PA_ROWS) : tile_rem;
  assign row_last  = RW'(tile_rows - 1'b1);
  assign col_last  = COL_AW'(rhs_cols_q - 1'b1);
  assign lhs_nxt   = {1'b0, lhs_base} + (CFG_W+1)'(LHS_STEP);
  assign tile_nxt  = {1'b0, tile_base} + (CFG_W+1)'(PA_ROWS);

`ifdef PA_TILE_SEQ_QUANT_PARAM_EN
  logic [1:0] trl_cnt;
  logic       trl_tc;

  pa_beat_cnt #(.W(2)) u_trl_cnt (
    .clk(clk), .counter_rst_n(counter_rst_n), .en(ld_beat & in_trl), .clr(st_chg),
    .last(2'(TRAILER_BEATS - 1)), .cnt(trl_cnt), .tc(trl_tc)
  );

  // After the last weight column of a row, the next beats carry bias/mult/shift.
  always_ff @(posedge clk or negedge counter_rst_n) begin
    if (!counter_rst_n) begin
      in_trl <= 1'b0;
    end else if (st_chg) begin
      in_trl <= 1'b0;
    end else if (ld_beat) begin
      if (!in_trl && col_tc) in_trl <= 1'b1;
      else if (in_trl && trl_tc) in_trl <= 1'b0;
    end
  end

  assign row_end    = ld_beat & in_trl & trl_tc;
  assign buf_wr     = ld_beat & in_trl;
  assign buf_wr_sel = trl_cnt;
`else
  assign in_trl     = 1'b0;
  assign row_end    = ld_beat & col_tc;
  assign buf_wr     = 1'b0;
  assign buf_wr_sel = SEL_BIAS;
`endif

  assign ram_wr = ld_beat & ~in_trl;

  pa_beat_cnt #(.W(COL_AW)) u_col_cnt (
    .clk(clk), .counter_rst_n(counter_rst_n), .en(ram_wr | comp_beat), .clr(st_chg),
    .last(col_last), .cnt(col_cnt), .tc(col_tc)
  );

  pa_beat_cnt #(.W(RW)) u_row_cnt (
    .clk(clk), .counter_rst_n(counter_rst_n), .en(row_end), .clr(st_chg),
    .last(row_last), .cnt(row_cnt), .tc(row_tc)
  );

  pa_beat_cnt #(.W(RW)) u_lane_cnt (
    .clk(clk), .counter_rst_n(counter_rst_n), .en(wb_beat), .clr(st_chg),
    .last(row_last), .cnt(lane_cnt), .tc(lane_tc)
  );

  always_comb begin
    st_nxt   = st;
    latch    = 1'b0;
    done_set = 1'b0;
    pass_adv = 1'b0;
    tile_adv = 1'b0;
    case (st)
      ST_IDLE: begin
        if (start) begin
          latch = 1'b1;
          if (rhs_rows == '0 || rhs_cols == '0 || lhs_rows == '0) done_set = 1'b1;
          else st_nxt = ST_LOADW;
        end
      end
      ST_LOADW: if (row_end && row_tc) st_nxt = ST_COMP;
      ST_COMP:  if (comp_beat && col_tc) st_nxt = ST_WB;
      ST_WB: begin
        if (wb_beat && lane_tc) begin
          if (lhs_nxt < {1'b0, lhs_rows_q}) begin
            st_nxt   = ST_COMP;
            pass_adv = 1'b1;
          end else if (tile_nxt < {1'b0, rhs_rows_q}) begin
            st_nxt   = ST_LOADW;
            tile_adv = 1'b1;
          end else begin
            st_nxt   = ST_IDLE;
            done_set = 1'b1;
          end
        end
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  assign st_chg = (st_nxt != st);

  always_ff @(posedge clk or negedge counter_rst_n) begin
    if (!counter_rst_n) begin
      st         <= ST_IDLE;
      rhs_rows_q <= '0;
      rhs_cols_q <= '0;
      lhs_rows_q <= '0;
      tile_base  <= '0;
      lhs_base   <= '0;
      comp_entry <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      st         <= st_nxt;
      done_q     <= done_set;
      comp_entry <= (st_nxt == ST_COMP) && (st != ST_COMP);
      if (latch) begin
        rhs_rows_q <= rhs_rows;
        rhs_cols_q <= rhs_cols;
        lhs_rows_q <= lhs_rows;
        tile_base  <= '0;
        lhs_base   <= '0;
      end
      if (tile_adv) tile_base <= tile_nxt[CFG_W-1:0];
      if (pass_adv) lhs_base <= lhs_nxt[CFG_W-1:0];
      if (st == ST_LOADW && st_nxt == ST_COMP) lhs_base <= '0;
    end
  end

  assign wr_ram_addr = {row_cnt, col_cnt};
  assign rd_ram_addr = col_cnt;
  assign result_addr = lane_cnt;
  assign pa_en       = comp_beat;
  assign row_sum_clr = comp_entry;
  assign state       = st;
  assign done        = done_q;

endmodule

// File: tb/tb_pa_tile_seq.sv
// Self-checking bench for pa_tile_seq: beat-level event stream versus a job-level model.
// Honours PA_TILE_SEQ_QUANT_PARAM_EN when it is defined for the build.
module tb_pa_tile_seq;

  localparam int PA_ROWS  = 16;
  localparam int LHS_STEP = 4;
  localparam int COL_AW   = 9;
  localparam int CFG_W    = 32;
  localparam int RW       = $clog2(PA_ROWS);
`ifdef PA_TILE_SEQ_QUANT_PARAM_EN
  localparam int TRL = 3;
`else
  localparam int TRL = 0;
`endif

  logic clk, counter_rst_n, start;
  logic [CFG_W-1:0] rhs_rows, rhs_cols, lhs_rows;
  logic data_rd_rdy, data_rd_acq, weight_rd_rdy, weight_rd_acq;
  logic dst_wr_rdy, dst_wr_acq, ram_wr, buf_wr, pa_en, row_sum_clr, done;
  logic [RW+COL_AW-1:0] wr_ram_addr;
  logic [COL_AW-1:0] rd_ram_addr;
  logic [1:0] buf_wr_sel, state;
  logic [RW-1:0] result_addr;

  pa_tile_seq #(.PA_ROWS(PA_ROWS), .LHS_STEP(LHS_STEP), .COL_AW(COL_AW), .CFG_W(CFG_W)) dut (
    .clk(clk), .counter_rst_n(counter_rst_n), .start(start),
    .rhs_rows(rhs_rows), .rhs_cols(rhs_cols), .lhs_rows(lhs_rows),
    .data_rd_rdy(data_rd_rdy), .data_rd_acq(data_rd_acq),
    .weight_rd_rdy(weight_rd_rdy), .weight_rd_acq(weight_rd_acq),
    .dst_wr_rdy(dst_wr_rdy), .dst_wr_acq(dst_wr_acq),
    .wr_ram_addr(wr_ram_addr), .rd_ram_addr(rd_ram_addr), .ram_wr(ram_wr),
    .buf_wr(buf_wr), .buf_wr_sel(buf_wr_sel), .pa_en(pa_en), .row_sum_clr(row_sum_clr),
    .result_addr(result_addr), .state(state), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int obs_q[$];
  bit mon_en = 1'b0;
  bit w_rand = 1'b0;
  bit d_rand = 1'b0;
  int a_mode = 0;
  int hold_viol = 0;
  int hold_cmp = 0;

  // Event kinds: 0 ram_wr, 1 buf_wr, 2 compute beat, 3 result beat, 4 row_sum_clr, 5 done
  function automatic int ev(int kind, int addr);
    return (kind << 16) | addr;
  endfunction

  function automatic int cnt_kind(int kind);
    int n = 0;
    foreach (obs_q[i]) if ((obs_q[i] >> 16) == kind) n++;
    return n;
  endfunction

  function automatic int last_of_kind(int kind);
    int a = -1;
    foreach (obs_q[i]) if ((obs_q[i] >> 16) == kind) a = obs_q[i] & 32'hFFFF;
    return a;
  endfunction

  // Handshake driver
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    weight_rd_rdy = 1'b0;
    data_rd_rdy = 1'b0;
    dst_wr_acq = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      weight_rd_rdy = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      data_rd_rdy   = d_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (a_mode == 1 && state == 2'd3) begin
        if (stall_cnt < 5) begin
          dst_wr_acq = 1'b0;
          stall_cnt++;
        end else dst_wr_acq = 1'b1;
      end else if (a_mode == 2) begin
        dst_wr_acq = 1'($urandom_range(0, 1));
      end else begin
        dst_wr_acq = 1'b1;
        stall_cnt = 0;
      end
    end
  end

  // Event recorder and address-hold observer
  logic [1:0] p_state = 2'd0;
  logic p_ld = 1'b0, p_wb = 1'b0;
  logic [RW+COL_AW-1:0] p_wr = '0;
  logic [RW-1:0] p_res = '0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (row_sum_clr) obs_q.push_back(ev(4, 0));
      if (ram_wr) obs_q.push_back(ev(0, int'(wr_ram_addr)));
      if (buf_wr) obs_q.push_back(ev(1, int'(buf_wr_sel)));
      if (pa_en) obs_q.push_back(ev(2, int'(rd_ram_addr)));
      if (dst_wr_rdy && dst_wr_acq) obs_q.push_back(ev(3, int'(result_addr)));
      if (done) obs_q.push_back(ev(5, 0));
      if (p_state == 2'd1 && state == 2'd1 && !p_ld) begin
        hold_cmp <= hold_cmp + 1;
        if (wr_ram_addr !== p_wr) hold_viol <= hold_viol + 1;
      end
      if (p_state == 2'd3 && state == 2'd3 && !p_wb) begin
        hold_cmp <= hold_cmp + 1;
        if (result_addr !== p_res) hold_viol <= hold_viol + 1;
      end
    end
    p_state <= state;
    p_ld    <= weight_rd_rdy & weight_rd_acq;
    p_wb    <= dst_wr_rdy & dst_wr_acq;
    p_wr    <= wr_ram_addr;
    p_res   <= result_addr;
  end

  // Job-level reference: what the DMA and PA see for a whole job, in order.
  task automatic build_model(input int rr, input int rc, input int lr);
    exp_q.delete();
    if (rr == 0 || rc == 0 || lr == 0) begin
      exp_q.push_back(ev(5, 0));
      return;
    end
    for (int tb = 0; tb < rr; tb += PA_ROWS) begin
      int tr;
      tr = (rr - tb < PA_ROWS) ? rr - tb : PA_ROWS;
      for (int r = 0; r < tr; r++) begin
        for (int c = 0; c < rc; c++) exp_q.push_back(ev(0, r * (1 << COL_AW) + c));
        for (int s = 0; s < TRL; s++) exp_q.push_back(ev(1, s));
      end
      for (int lb = 0; lb < lr; lb += LHS_STEP) begin
        exp_q.push_back(ev(4, 0));
        for (int c = 0; c < rc; c++) exp_q.push_back(ev(2, c));
        for (int l = 0; l < tr; l++) exp_q.push_back(ev(3, l));
      end
    end
    exp_q.push_back(ev(5, 0));
  endtask

  task automatic run_job(input int rr, input int rc, input int lr, input int budget, output bit to);
    int n;
    build_model(rr, rc, lr);
    obs_q.delete();
    @(posedge clk);
    #1;
    rhs_rows = rr; rhs_cols = rc; lhs_rows = lr;
    start = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rhs_rows = $urandom; rhs_cols = $urandom; lhs_rows = $urandom;
    to = 1'b1;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
    @(negedge clk);
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    counter_rst_n = 1'b0;
    start = 1'b0;
    rhs_rows = '0; rhs_cols = '0; lhs_rows = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++;
    if ({weight_rd_acq, data_rd_acq, dst_wr_rdy} !== 3'b000) begin
      errors++; $display("FAIL reset_acq: got %b expected 000", {weight_rd_acq, data_rd_acq, dst_wr_rdy});
    end
    checks++;
    if ({ram_wr, buf_wr, pa_en, row_sum_clr, done} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 00000", {ram_wr, buf_wr, pa_en, row_sum_clr, done});
    end
    checks++;
    if ({wr_ram_addr, rd_ram_addr, result_addr, buf_wr_sel} !== '0) begin
      errors++; $display("FAIL reset_addr: got wr %0d rd %0d res %0d sel %0d expected 0", wr_ram_addr, rd_ram_addr, result_addr, buf_wr_sel);
    end
    counter_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 2'd0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got state %0d done %0d expected 0 0", state, done); end
  endtask

  task automatic test_single_tile();
    bit to;
    int nerr;
    w_rand = 0; d_rand = 0; a_mode = 0;
    run_job(16, 8, 4, 3000, to);
    checks++;
    if (to) begin errors++; $display("FAIL single_timeout: got no done expected done"); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_events: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    nerr = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        if (nerr < 4) $display("FAIL single_ev[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
        nerr++;
      end
    end
    checks++;
    if (cnt_kind(0) !== 128) begin errors++; $display("FAIL single_loadw_beats: got %0d expected 128", cnt_kind(0)); end
    checks++;
    if (cnt_kind(2) !== 8) begin errors++; $display("FAIL single_comp_beats: got %0d expected 8", cnt_kind(2)); end
    checks++;
    if (cnt_kind(3) !== 16) begin errors++; $display("FAIL single_wb_beats: got %0d expected 16", cnt_kind(3)); end
    checks++;
    if (cnt_kind(4) !== 1) begin errors++; $display("FAIL single_passes: got %0d expected 1", cnt_kind(4)); end
    checks++;
    if (last_of_kind(0) !== 15 * 512 + 7) begin errors++; $display("FAIL single_last_wr: got %0d expected %0d", last_of_kind(0), 15 * 512 + 7); end
  endtask

  task automatic test_multi_tile();
    bit to;
    int nerr;
    w_rand = 0; d_rand = 1; a_mode = 0;
    run_job(20, 8, 8, 5000, to);
    checks++;
    if (to) begin errors++; $display("FAIL multi_timeout: got no done expected done"); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL multi_events: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    nerr = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        if (nerr < 4) $display("FAIL multi_ev[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
        nerr++;
      end
    end
    checks++;
    if (cnt_kind(0) !== 160) begin errors++; $display("FAIL multi_loadw_beats: got %0d expected 160", cnt_kind(0)); end
    checks++;
    if (cnt_kind(4) !== 4) begin errors++; $display("FAIL multi_passes: got %0d expected 4", cnt_kind(4)); end
    checks++;
    if (cnt_kind(3) !== 40) begin errors++; $display("FAIL multi_wb_beats: got %0d expected 40", cnt_kind(3)); end
  endtask

  task automatic test_quant_trailer();
    bit to;
    int nerr;
    w_rand = 0; d_rand = 0; a_mode = 0;
    run_job(2, 4, 4, 2000, to);
    checks++;
    if (to) begin errors++; $display("FAIL trailer_timeout: got no done expected done"); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL trailer_events: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    nerr = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        if (nerr < 4) $display("FAIL trailer_ev[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
        nerr++;
      end
    end
    checks++;
    if (cnt_kind(0) + cnt_kind(1) !== 8 + 2 * TRL) begin
      errors++; $display("FAIL trailer_loadw_total: got %0d expected %0d", cnt_kind(0) + cnt_kind(1), 8 + 2 * TRL);
    end
  endtask

  task automatic test_stall();
    bit to;
    int nerr, v0, c0;
    v0 = hold_viol; c0 = hold_cmp;
    w_rand = 1; d_rand = 1; a_mode = 1;
    run_job(18, 5, 6, 8000, to);
    checks++;
    if (to) begin errors++; $display("FAIL stall_timeout: got no done expected done"); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_events: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    nerr = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        if (nerr < 4) $display("FAIL stall_ev[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
        nerr++;
      end
    end
    checks++;
    if (hold_viol - v0 !== 0) begin errors++; $display("FAIL stall_addr_hold: got %0d moves expected 0", hold_viol - v0); end
    checks++;
    if (hold_cmp - c0 < 10) begin errors++; $display("FAIL stall_observed: got %0d stalled cycles expected at least 10", hold_cmp - c0); end
    a_mode = 0;
  endtask

  task automatic test_zero_size();
    bit to;
    w_rand = 0; d_rand = 0; a_mode = 0;
    @(posedge clk);
    #1;
    rhs_rows = 16; rhs_cols = 8; lhs_rows = 0;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_done_early: got %0d expected 0", done); end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || state !== 2'd0) begin errors++; $display("FAIL zero_done_pulse: got done %0d state %0d expected 1 0", done, state); end
    checks++;
    if ({weight_rd_acq, data_rd_acq, dst_wr_rdy} !== 3'b000) begin
      errors++; $display("FAIL zero_acq: got %b expected 000", {weight_rd_acq, data_rd_acq, dst_wr_rdy});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL zero_done_width: got done %0d state %0d expected 0 0", done, state); end
    run_job(0, 5, 3, 50, to);
    checks++;
    if (to || obs_q.size() !== 1) begin errors++; $display("FAIL zero_rhs_job: got %0d events expected 1", obs_q.size()); end
  endtask

  task automatic test_reset_mid_comp();
    bit to, seen_done;
    int n, nerr;
    w_rand = 0; d_rand = 1; a_mode = 0;
    @(posedge clk);
    #1;
    rhs_rows = 16; rhs_cols = 8; lhs_rows = 4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (state !== 2'd2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL rst_reach_comp: got state %0d expected 2", state); end
    repeat (2) @(negedge clk);
    counter_rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL rst_mid_state: got %0d expected 0", state); end
    checks++;
    if ({data_rd_acq, pa_en, row_sum_clr, rd_ram_addr, wr_ram_addr} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got acq %0d pa_en %0d rd %0d wr %0d expected 0", data_rd_acq, pa_en, rd_ram_addr, wr_ram_addr);
    end
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    counter_rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: got %0d expected 0", seen_done); end
    run_job(16, 8, 4, 3000, to);
    checks++;
    if (to || obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rst_rerun_events: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    nerr = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        if (nerr < 4) $display("FAIL rst_rerun_ev[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
        nerr++;
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int rr, rc, lr, nerr;
    for (int j = 0; j < 5; j++) begin
      rr = $urandom_range(1, 40);
      rc = $urandom_range(1, 12);
      lr = $urandom_range(1, 10);
      w_rand = 1'($urandom_range(0, 1));
      d_rand = 1'($urandom_range(0, 1));
      a_mode = 2 * $urandom_range(0, 1);
      run_job(rr, rc, lr, 6000, to);
      checks++;
      if (to || obs_q.size() !== exp_q.size()) begin
        errors++; $display("FAIL b2b_events job %0d (%0dx%0d lhs %0d): got %0d expected %0d", j, rr, rc, lr, obs_q.size(), exp_q.size());
      end
      nerr = 0;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          if (nerr < 4) $display("FAIL b2b_ev job %0d [%0d]: got %h expected %h", j, i, obs_q[i], exp_q[i]);
          nerr++;
        end
      end
    end
    a_mode = 0;
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_quant_trailer();
    test_stall();
    test_zero_size();
    test_reset_mid_comp();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
